// File: rtl/hazard_fwd_ctrl.sv
// hazard_fwd_ctrl: EX operand forwarding select and data-memory wait stall control
module hazard_fwd_ctrl #(
    parameter int NRS   = 2,
    parameter int AW    = 5,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [NRS*AW-1:0] ex_rs_addr,
    input  logic [NRS-1:0]    ex_rs_used,
    input  logic [AW-1:0]     mem_rd,
    input  logic              mem_we_reg,
    input  logic              mem_re_mem,
    input  logic              mem_we_mem,
    input  logic              mem_ready,
    input  logic [AW-1:0]     wb_rd,
    input  logic              wb_we_reg,
    input  logic              flush,
    input  logic              cnt_clr,
    output logic [NRS*2-1:0]  fwd_sel,
    output logic [NRS-1:0]    fwd_held,
    output logic              stall,
    output logic              hold_en,
    output logic [CNT_W-1:0]  stall_cnt
);
    typedef enum logic {RUN, WAIT} state_t;
    state_t        state;
    logic          held_valid;
    logic [AW-1:0] held_rd;
    logic          mem_busy;
    assign mem_busy = (mem_re_mem | mem_we_mem) & ~mem_ready;
    assign stall    = ~flush & (state == RUN ? mem_busy : ~mem_ready);
    assign hold_en  = ~flush & (state == RUN) & mem_busy;
    // the WB result leaves the pipeline during the freeze, so it is captured on entry to WAIT
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= RUN;
            held_valid <= 1'b0;
            held_rd    <= '0;
            stall_cnt  <= '0;
        end else begin
            state <= flush ? RUN : state == RUN ? (mem_busy ? WAIT : RUN) : (mem_ready ? RUN : WAIT);
            if (hold_en) begin
                held_rd    <= wb_rd;
                held_valid <= wb_we_reg & (wb_rd != '0);
            end else if (!stall) begin
                held_valid <= 1'b0;
            end
            stall_cnt <= cnt_clr ? '0 : (stall && !(&stall_cnt)) ? stall_cnt + CNT_W'(1) : stall_cnt;
        end
    end
    for (genvar i = 0; i < NRS; i++) begin : g_op
        logic [AW-1:0] a;
        logic          skip, hit_mem, hit_wb, hit_held;
        assign a        = ex_rs_addr[i*AW +: AW];
        assign skip     = ~ex_rs_used[i] | (a == '0);
        assign hit_mem  = mem_we_reg & (a == mem_rd);
        assign hit_wb   = wb_we_reg & (a == wb_rd);
        assign hit_held = held_valid & (a == held_rd);
        assign fwd_sel[2*i +: 2] = skip ? 2'b00 : hit_mem ? {mem_re_mem, 1'b1} :
                                   (hit_wb | hit_held) ? 2'b10 : 2'b00;
        assign fwd_held[i] = ~skip & ~hit_mem & ~hit_wb & hit_held;
    end
endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// tb_hazard_fwd_ctrl: directed vectors for forwarding priority, load wait, flush, saturation and reset
module tb_hazard_fwd_ctrl;
    logic        clk = 1'b0;
    logic        rstn;
    logic [9:0]  ex_rs_addr;
    logic [1:0]  ex_rs_used;
    logic [4:0]  mem_rd, wb_rd;
    logic        mem_we_reg, mem_re_mem, mem_we_mem, mem_ready, wb_we_reg, flush, cnt_clr;
    logic [3:0]  fwd_sel, fwd_sel_s;
    logic [1:0]  fwd_held, fwd_held_s;
    logic        stall, hold_en, stall_s, hold_en_s;
    logic [15:0] stall_cnt;
    logic [1:0]  stall_cnt_s;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    hazard_fwd_ctrl dut (
        .clk(clk), .rstn(rstn), .ex_rs_addr(ex_rs_addr), .ex_rs_used(ex_rs_used),
        .mem_rd(mem_rd), .mem_we_reg(mem_we_reg), .mem_re_mem(mem_re_mem), .mem_we_mem(mem_we_mem),
        .mem_ready(mem_ready), .wb_rd(wb_rd), .wb_we_reg(wb_we_reg), .flush(flush), .cnt_clr(cnt_clr),
        .fwd_sel(fwd_sel), .fwd_held(fwd_held), .stall(stall), .hold_en(hold_en), .stall_cnt(stall_cnt)
    );

    hazard_fwd_ctrl #(.CNT_W(2)) dut_s (
        .clk(clk), .rstn(rstn), .ex_rs_addr(ex_rs_addr), .ex_rs_used(ex_rs_used),
        .mem_rd(mem_rd), .mem_we_reg(mem_we_reg), .mem_re_mem(mem_re_mem), .mem_we_mem(mem_we_mem),
        .mem_ready(mem_ready), .wb_rd(wb_rd), .wb_we_reg(wb_we_reg), .flush(flush), .cnt_clr(cnt_clr),
        .fwd_sel(fwd_sel_s), .fwd_held(fwd_held_s), .stall(stall_s), .hold_en(hold_en_s), .stall_cnt(stall_cnt_s)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic ctl(input string tag, input logic s, input logic h, input logic [3:0] fs, input logic [1:0] fh, input logic [15:0] c);
        chk({tag, "_stall"}, 32'(stall), 32'(s));
        chk({tag, "_hold"}, 32'(hold_en), 32'(h));
        chk({tag, "_sel"}, 32'(fwd_sel), 32'(fs));
        chk({tag, "_held"}, 32'(fwd_held), 32'(fh));
        chk({tag, "_cnt"}, 32'(stall_cnt), 32'(c));
    endtask

    initial begin
        rstn = 1'b0; ex_rs_addr = '0; ex_rs_used = '0; mem_rd = '0; wb_rd = '0;
        mem_we_reg = 0; mem_re_mem = 0; mem_we_mem = 0; mem_ready = 0; wb_we_reg = 0; flush = 0; cnt_clr = 0;
        #1 ctl("rst", 0, 0, 4'b0000, 2'b00, 0);
        @(negedge clk); @(negedge clk); rstn = 1'b1;
        #1 ctl("post_rst", 0, 0, 4'b0000, 2'b00, 0);
        // forwarding priority
        @(negedge clk);
        ex_rs_addr = {5'd0, 5'd5}; ex_rs_used = 2'b11; mem_rd = 5'd5; mem_we_reg = 1; wb_rd = 5'd5; wb_we_reg = 1;
        #1 chk("mem_beats_wb", 32'(fwd_sel), 32'h1);
        mem_rd = 5'd0;
        #1 chk("rs1_zero_wb_rs0", 32'(fwd_sel), 32'h2);
        ex_rs_addr = {5'd5, 5'd5}; ex_rs_used = 2'b01; mem_rd = 5'd5;
        #1 chk("rs1_unused", 32'(fwd_sel), 32'h1);
        mem_re_mem = 1; mem_ready = 1;
        #1 ctl("load_ready", 0, 0, 4'b0011, 2'b00, 0);
        mem_re_mem = 0; mem_we_reg = 0; wb_we_reg = 0;
        #1 ctl("ready_noreq", 0, 0, 4'b0000, 2'b00, 0);
        // load stalls three cycles
        @(negedge clk);
        mem_rd = 5'd3; mem_we_reg = 1; mem_re_mem = 1; mem_ready = 0; wb_rd = 5'd7; wb_we_reg = 1;
        ex_rs_addr = {5'd0, 5'd7}; ex_rs_used = 2'b01;
        #1 ctl("ld_a", 1, 1, 4'b0010, 2'b00, 0);
        @(negedge clk); wb_rd = 5'd0; wb_we_reg = 0;
        #1 ctl("ld_b", 1, 0, 4'b0010, 2'b01, 1);
        @(negedge clk);
        #1 ctl("ld_c", 1, 0, 4'b0010, 2'b01, 2);
        @(negedge clk); mem_ready = 1;
        #1 ctl("ld_d", 0, 0, 4'b0010, 2'b01, 3);
        // back in RUN: a new store request raises hold_en again
        @(negedge clk);
        mem_re_mem = 0; mem_we_reg = 0; mem_we_mem = 1; mem_ready = 0; wb_rd = 5'd7; wb_we_reg = 1;
        #1 ctl("st_e", 1, 1, 4'b0010, 2'b00, 3);
        @(negedge clk); wb_we_reg = 0;
        #1 ctl("st_f", 1, 0, 4'b0010, 2'b01, 4);
        @(negedge clk); flush = 1;
        #1 ctl("flush_g", 0, 0, 4'b0010, 2'b01, 5);
        chk("sat_small", 32'(stall_cnt_s), 32'd3);
        @(negedge clk); flush = 0;
        #1 ctl("after_flush_h", 1, 1, 4'b0000, 2'b00, 5);
        @(negedge clk); mem_ready = 1;
        #1 ctl("ready_i", 0, 0, 4'b0000, 2'b00, 6);
        chk("sat_small_i", 32'(stall_cnt_s), 32'd3);
        // clear wins over increment
        @(negedge clk);
        mem_ready = 0; cnt_clr = 1; wb_rd = 5'd9; wb_we_reg = 1; ex_rs_addr = {5'd0, 5'd9};
        #1 ctl("clr_j", 1, 1, 4'b0010, 2'b00, 6);
        @(negedge clk); cnt_clr = 0; wb_we_reg = 0;
        #1 ctl("clr_k", 1, 0, 4'b0010, 2'b01, 0);
        chk("clr_small", 32'(stall_cnt_s), 32'd0);
        @(negedge clk);
        #1 ctl("wait_l", 1, 0, 4'b0010, 2'b01, 1);
        // asynchronous reset in the middle of WAIT
        #1 rstn = 1'b0;
        #1 chk("arst_cnt", 32'(stall_cnt), 32'd0);
        chk("arst_held", 32'(fwd_held), 32'd0);
        chk("arst_cnt_small", 32'(stall_cnt_s), 32'd0);
        mem_we_mem = 0;
        #1 chk("arst_stall", 32'(stall), 32'd0);
        @(negedge clk); rstn = 1'b1;
        #1 ctl("rel_m", 0, 0, 4'b0000, 2'b00, 0);
        @(negedge clk);
        #1 ctl("rel_n", 0, 0, 4'b0000, 2'b00, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/hazard_fwd_ctrl.md
HAZARD_FWD_CTRL -- requirements
Module: hazard_fwd_ctrl

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- NRS, 2, number of EX source operands (2..3)
- AW, 5, register address width
- CNT_W, 16, stall-cycle counter width
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
- clk  in  1  single clock, rising edge
- rstn  in  1  asynchronous active-low reset
- ex_rs_addr  in  NRS*AW  EX source addresses; operand i at [i*AW +: AW]
- ex_rs_used  in  NRS  operand i actually read by EX instruction
- mem_rd  in  AW  MEM-stage destination
- mem_we_reg  in  1  MEM instruction writes register file
- mem_re_mem  in  1  MEM instruction is a load
- mem_we_mem  in  1  MEM instruction is a store
- mem_ready  in  1  data memory completes the MEM access this cycle
- wb_rd  in  AW  WB-stage destination
- wb_we_reg  in  1  WB instruction writes register file
- flush  in  1  pipeline redirect
- cnt_clr  in  1  synchronous clear of stall_cnt
- fwd_sel  out  NRS*2  per-operand source: 00 regfile, 01 MEM ALU result, 10 WB result, 11 MEM load data
- fwd_held  out  NRS  operand i takes held WB bypass register instead of live WB
- stall  out  1  freeze PC, IF/ID, ID/EX, EX/MEM; bubble into MEM/WB
- hold_en  out  1  datapath captures WB result into held bypass register this edge
- stall_cnt  out  CNT_W  saturating count of stalled cycles

Function
REQ-003 mem_busy SHALL equal (mem_re_mem | mem_we_mem) & ~mem_ready.
REQ-004 FSM states SHALL be RUN and WAIT; reset state RUN.
REQ-005 RUN: mem_busy & ~flush SHALL move to WAIT at next edge, with stall=1 and hold_en=1 combinationally in that same cycle.
REQ-006 WAIT: stall SHALL equal ~mem_ready; mem_ready SHALL return to RUN at next edge with stall=0 in the ready cycle; hold_en SHALL be 0 in WAIT.
REQ-007 flush SHALL force RUN at next edge, force stall=0 and hold_en=0 combinationally, and clear held_valid.
REQ-008 On an edge with hold_en=1, held_rd<=wb_rd and held_valid<=wb_we_reg & (wb_rd!=0).
REQ-009 held_valid SHALL clear on any edge where stall=0 and hold_en=0.
REQ-010 For each operand i with a=ex_rs_addr[i], priority SHALL be: ~ex_rs_used[i] or a==0 -> 00; a==mem_rd & mem_we_reg -> 11 if mem_re_mem else 01; a==wb_rd & wb_we_reg -> 10; held_valid & a==held_rd -> 10 with fwd_held[i]=1; else 00.
REQ-011 fwd_held[i] SHALL be 1 only in the held case of REQ-010.
REQ-012 fwd_sel and fwd_held SHALL be purely combinational, zero latency.
REQ-013 stall_cnt SHALL increment by 1 per edge with stall=1, saturate at all-ones, and reset to 0 on edge with cnt_clr=1 (cnt_clr wins over increment).
REQ-014 mem_ready=1 with no MEM request SHALL have no effect.

Reset
REQ-015 rstn=0 SHALL asynchronously force state RUN, held_valid=0, held_rd=0, stall_cnt=0.
REQ-016 During and after reset with all inputs 0: fwd_sel=0, fwd_held=0, stall=0, hold_en=0.
REQ-017 Reset asserted in WAIT SHALL abandon the wait; first post-reset cycle is RUN.

Verification
REQ-018 Bench SHALL cover:
- mem_rd=5, mem_we_reg=1, mem_re_mem=0, rs0=5 used, wb_rd=5 we -> fwd_sel[1:0]=01 (MEM beats WB).
- rs1=0 used, mem_rd=0 we -> fwd_sel[3:2]=00; ex_rs_used[1]=0 with match -> 00.
- Load in MEM, mem_ready=0 for 3 cycles then 1, wb_rd=7 we, rs0=7 -> hold_en=1 first cycle only, stall=1 for 3 cycles, fwd_sel=10 with fwd_held[0]=1 during WAIT, stall_cnt=3, RUN after ready.
- flush in WAIT with mem_ready=0 -> stall=0 same cycle, RUN next edge, held_valid=0.
- CNT_W=2, 5 stall cycles -> stall_cnt saturates at 3; cnt_clr with stall=1 -> 0.
- rstn low mid-WAIT -> all state cleared immediately, stall=0 after release.
